// File: rtl/note_duration_sequencer.sv
// Purpose : steps through the score ROM, holding each pitch for dur x tick period, with a silent gap after each note.
// Latency : FETCH + LOAD (2 cycles) before a note sounds; each note occupies 2 + dur*TICK_DIV + GAP_TICKS*TICK_DIV + 1 cycles.
// Backpressure : none; the ROM is always ready, and stop aborts playback to IDLE on the next edge.
//
// Ports
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   start        begins playback from address 0 when idle (level or pulse)
//   stop         aborts playback; wins over start
//   dur_units    beat-unit count of the current score word (0 is played as 1)
//   pitch_in     pitch field of the current score word (END_CODE ends the song)
//   score_addr   score ROM address (ROM has one cycle of read latency)
//   pitch_out    held pitch code, 0 = rest
//   note_active  high while a note sounds
//   busy         high in every state except IDLE
//   done         one-cycle pulse at end of song
//
// Optional feature macro: LOOP_PLAY_EN
//   defined   : end of song pulses done, rewinds to address 0 and keeps playing until stop/reset
//   undefined : end of song returns to IDLE
//
// Parameter constraints: TICK_DIV >= 2, SONG_LEN <= 2**ADDR_W.

module note_duration_sequencer #(
   parameter int unsigned TICK_DIV  = 781250,
   parameter int unsigned GAP_TICKS = 2,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned SONG_LEN  = 48,
   parameter logic [4:0]  END_CODE  = 5'h1F
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [5:0]        dur_units,
   input  logic [4:0]        pitch_in,
   output logic [ADDR_W-1:0] score_addr,
   output logic [4:0]        pitch_out,
   output logic              note_active,
   output logic              busy,
   output logic              done
);

   // Prescaler is just wide enough for 0..TICK_DIV-1.
   localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // The beat counter is reused for the gap, so it must hold both a 6-bit
   // duration and GAP_TICKS.
   localparam int unsigned GAP_W  = $clog2(GAP_TICKS + 1);
   localparam int unsigned BEAT_W = (GAP_W > 6) ? GAP_W : 6;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [BEAT_W-1:0]  GAP_LOAD   = BEAT_W'(GAP_TICKS);
   localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
   localparam bit                 HAS_GAP    = (GAP_TICKS > 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_ADVANCE
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [PRESC_W-1:0]  presc_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [4:0]          pitch_q;
   logic                active_q;
   logic                busy_q;
   logic                done_q;

   logic                tick;
   logic                last_beat;
   logic                at_last;
   logic                load_end;
   logic [PRESC_W-1:0]  presc_d;
   logic [BEAT_W-1:0]   beat_d;
   logic [BEAT_W-1:0]   dur_load;

   // Shared timing for PLAY and GAP: the prescaler wraps once per beat unit,
   // and the wrap that takes beat_q from 1 to 0 is the last cycle of the state.
   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
      beat_d    = tick ? beat_q - BEAT_W'(1) : beat_q;
      last_beat = tick && (beat_q == BEAT_W'(1));
      at_last   = (addr_q == LAST_ADDR);
      // A zero duration would underflow the counter, so it is played as one unit.
      dur_load  = (dur_units == 6'd0) ? BEAT_W'(1) : BEAT_W'(dur_units);
      // The end code is only visible in LOAD (ROM data arrives that cycle),
      // so this part of done is decoded rather than registered.
      load_end  = (state_q == S_LOAD) && (pitch_in == END_CODE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || (stop && (state_q != S_IDLE))) begin
         // Reset and stop share one path: stop leaves everything exactly as reset does.
         state_q  <= S_IDLE;
         addr_q   <= '0;
         presc_q  <= '0;
         beat_q   <= '0;
         pitch_q  <= '0;
         active_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               addr_q <= '0;
               if (start && !stop) begin
                  state_q <= S_FETCH;
                  busy_q  <= 1'b1;
               end
            end

            // Address has been on the ROM since entry; data lands at the end of this cycle.
            S_FETCH: begin
               state_q <= S_LOAD;
            end

            S_LOAD: begin
               if (pitch_in == END_CODE) begin
                  addr_q <= '0;
`ifdef LOOP_PLAY_EN
                  state_q <= S_FETCH;
`else
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  beat_q   <= dur_load;
                  presc_q  <= '0;
                  pitch_q  <= pitch_in;
                  active_q <= 1'b1;
                  state_q  <= S_PLAY;
               end
            end

            S_PLAY: begin
               presc_q <= presc_d;
               beat_q  <= beat_d;
               if (last_beat) begin
                  pitch_q  <= '0;
                  active_q <= 1'b0;
                  if (HAS_GAP) begin
                     // presc_d is already 0 on the wrapping cycle.
                     beat_q  <= GAP_LOAD;
                     state_q <= S_GAP;
                  end else begin
                     state_q <= S_ADVANCE;
                     done_q  <= at_last;
                  end
               end
            end

            S_GAP: begin
               presc_q <= presc_d;
               beat_q  <= beat_d;
               if (last_beat) begin
                  state_q <= S_ADVANCE;
                  done_q  <= at_last;
               end
            end

            S_ADVANCE: begin
               if (at_last) begin
                  addr_q <= '0;
`ifdef LOOP_PLAY_EN
                  state_q <= S_FETCH;
`else
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  state_q <= S_FETCH;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign score_addr  = addr_q;
   assign pitch_out   = pitch_q;
   assign note_active = active_q;
   assign busy        = busy_q;
   // done_q is raised on entry to the final ADVANCE; a stop in that cycle cancels the pulse.
   assign done        = (done_q | load_end) & ~stop;

endmodule

// File: tb/tb_note_duration_sequencer.sv
module tb_note_duration_sequencer;

   localparam int AW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, stop, start_a, start_b;
   logic [5:0]    dur_a, dur_b;
   logic [4:0]    pit_a, pit_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [4:0]    pout_a, pout_b;
   logic          act_a, act_b, busy_a, busy_b, done_a, done_b;

   // Score ROM models: {dur[5:0], pitch[4:0]}, one cycle read latency.
   logic [10:0] rom_a [4];
   logic [10:0] rom_b [4];
   logic [10:0] rq_a, rq_b;
   always @(posedge clk) begin
      rq_a <= rom_a[addr_a[1:0]];
      rq_b <= rom_b[addr_b[1:0]];
   end
   assign dur_a = rq_a[10:5];
   assign pit_a = rq_a[4:0];
   assign dur_b = rq_b[10:5];
   assign pit_b = rq_b[4:0];

   note_duration_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(AW), .SONG_LEN(4), .END_CODE(5'h1F)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .dur_units(dur_a), .pitch_in(pit_a),
      .score_addr(addr_a), .pitch_out(pout_a), .note_active(act_a), .busy(busy_a), .done(done_a));

   note_duration_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .ADDR_W(AW), .SONG_LEN(4), .END_CODE(5'h1F)) dut_nogap (
      .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .dur_units(dur_b), .pitch_in(pit_b),
      .score_addr(addr_b), .pitch_out(pout_b), .note_active(act_b), .busy(busy_b), .done(done_b));

   // Scoreboard entry: an output tuple and how many consecutive cycles it must hold.
   typedef struct packed {
      logic [13:0] tup;
      logic [15:0] len;
   } run_t;

   run_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   logic        mon_en = 1'b0;
   logic        sel_b  = 1'b0;
   logic        have   = 1'b0;
   logic [13:0] run_tup;
   int          run_len;

   function automatic logic [13:0] mk(input logic b, input logic a, input logic [4:0] p,
                                      input logic [5:0] ad, input logic d);
      return {b, a, p, ad, d};
   endfunction

   task automatic push(input logic [13:0] t, input int n);
      run_t r;
      r.tup = t;
      r.len = n[15:0];
      exp_q.push_back(r);
   endtask

   task automatic check_run(input logic [13:0] t, input int n);
      run_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL run: got busy/act/pitch/addr/done=%b/%b/%0d/%0d/%b len=%0d, expected no further run",
                  t[13], t[12], t[11:7], t[6:1], t[0], n);
      end else begin
         e = exp_q.pop_front();
         if (e.tup !== t || e.len != n[15:0]) begin
            bad++;
            $display("FAIL run: got busy/act/pitch/addr/done=%b/%b/%0d/%0d/%b len=%0d, expected %b/%b/%0d/%0d/%b len=%0d",
                     t[13], t[12], t[11:7], t[6:1], t[0], n,
                     e.tup[13], e.tup[12], e.tup[11:7], e.tup[6:1], e.tup[0], e.len);
         end
      end
   endtask

   // Monitor: run-length encodes the selected DUT's outputs and checks each
   // completed run against the next expected entry.
   initial begin
      logic [13:0] cur;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = sel_b ? mk(busy_b, act_b, pout_b, addr_b, done_b)
                        : mk(busy_a, act_a, pout_a, addr_a, done_a);
            if (have && cur === run_tup) begin
               run_len++;
            end else begin
               if (have) check_run(run_tup, run_len);
               run_tup = cur;
               run_len = 1;
               have    = 1'b1;
            end
         end
      end
   end

   task automatic flush();
      if (have) check_run(run_tup, run_len);
      have = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected runs for one note: FETCH+LOAD, PLAY, then GAP+ADVANCE (done shows in the final ADVANCE).
   task automatic push_note(input int ad, input int d, input int p, input bit last, input int gap);
      push(mk(1, 0, 5'd0, 6'(ad), 0), 2);
      push(mk(1, 1, 5'(p), 6'(ad), 0), 4 * d);
      if (!last) begin
         push(mk(1, 0, 5'd0, 6'(ad), 0), 4 * gap + 1);
      end else begin
         if (gap > 0) push(mk(1, 0, 5'd0, 6'(ad), 0), 4 * gap);
         push(mk(1, 0, 5'd0, 6'(ad), 1), 1);
      end
   endtask

   task automatic push_song_a();
      push_note(0, 2, 5, 0, 1);
      push_note(1, 1, 3, 0, 1);
      push_note(2, 4, 7, 0, 1);
      push_note(3, 1, 2, 1, 1);
   endtask

   task automatic load_roms();
      rom_a[0] = {6'd2, 5'd5};
      rom_a[1] = {6'd1, 5'd3};
      rom_a[2] = {6'd4, 5'd7};
      rom_a[3] = {6'd1, 5'd2};
      rom_b[0] = {6'd0, 5'd5};
      rom_b[1] = {6'd1, 5'd3};
      rom_b[2] = {6'd4, 5'd7};
      rom_b[3] = {6'd1, 5'd2};
   endtask

   localparam logic [13:0] IDLE_T = 14'd0;

   // Full song on the gapped DUT, with a start pulse mid-song that must be ignored.
   task automatic single_pass();
      push(IDLE_T, 1);
      push_song_a();
      push(IDLE_T, 10);
      start_a = 1'b1;
      cyc(1);  start_a = 1'b0;
      cyc(19); start_a = 1'b1;
      cyc(1);  start_a = 1'b0;
      cyc(50);
      flush();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion before it");
      $fatal(1, "watchdog");
   end

   initial begin
      load_roms();
      rst_n = 1'b0; stop = 1'b0; start_a = 1'b0; start_b = 1'b0;
      cyc(3);

      // Reset / idle, including start+stop together while idle (stop wins).
      rst_n = 1'b1; mon_en = 1'b1;
      push(IDLE_T, 20);
      cyc(5); start_a = 1'b1; stop = 1'b1;
      cyc(1); start_a = 1'b0; stop = 1'b0;
      cyc(14);
      flush();

`ifdef LOOP_PLAY_EN
      // Two full songs, then stop three cycles into note 2 of the third.
      push(IDLE_T, 1);
      push_song_a();
      push_song_a();
      push_note(0, 2, 5, 0, 1);
      push_note(1, 1, 3, 0, 1);
      push(mk(1, 0, 5'd0, 6'd2, 0), 2);
      push(mk(1, 1, 5'd7, 6'd2, 0), 3);
      push(IDLE_T, 8);
      start_a = 1'b1;
      cyc(1);   start_a = 1'b0;
      cyc(150); stop = 1'b1;
      cyc(1);   stop = 1'b0;
      cyc(8);
      flush();
`else
      single_pass();

      // End code at address 1: done in LOAD, pitch 3 never sounds.
      rom_a[1] = {6'd1, 5'h1F};
      push(IDLE_T, 1);
      push_note(0, 2, 5, 0, 1);
      push(mk(1, 0, 5'd0, 6'd1, 0), 1);
      push(mk(1, 0, 5'd0, 6'd1, 1), 1);
      push(IDLE_T, 10);
      start_a = 1'b1;
      cyc(1);  start_a = 1'b0;
      cyc(27);
      flush();
      rom_a[1] = {6'd1, 5'd3};

      // Stop three cycles into note 2 (start also high: stop wins), then replay.
      push(IDLE_T, 1);
      push_note(0, 2, 5, 0, 1);
      push_note(1, 1, 3, 0, 1);
      push(mk(1, 0, 5'd0, 6'd2, 0), 2);
      push(mk(1, 1, 5'd7, 6'd2, 0), 3);
      push(IDLE_T, 8);
      start_a = 1'b1;
      cyc(1);  start_a = 1'b0;
      cyc(30); stop = 1'b1; start_a = 1'b1;
      cyc(1);  stop = 1'b0; start_a = 1'b0;
      cyc(8);
      flush();
      single_pass();

      // No-gap DUT with a zero duration at address 0 (played as one unit).
      sel_b = 1'b1;
      push(IDLE_T, 1);
      push_note(0, 1, 5, 0, 0);
      push_note(1, 1, 3, 0, 0);
      push_note(2, 4, 7, 0, 0);
      push_note(3, 1, 2, 1, 0);
      push(IDLE_T, 10);
      start_b = 1'b1;
      cyc(1);  start_b = 1'b0;
      cyc(50);
      flush();
      sel_b = 1'b0;
`endif

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: %0d expected runs never observed, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
